// File: rtl/alu_issue_wb_pkg.sv
// Shared opcode map and legality check for the ALU execute/writeback shell.
package alu_issue_wb_pkg;

   localparam int OP_W = 8;

   localparam logic [OP_W-1:0] OP_ADD = 8'h00;
   localparam logic [OP_W-1:0] OP_SUB = 8'h01;
   localparam logic [OP_W-1:0] OP_MUL = 8'h02;
   localparam logic [OP_W-1:0] OP_DIV = 8'h03;
   localparam logic [OP_W-1:0] OP_CMP = 8'h04;
   localparam logic [OP_W-1:0] OP_NOT = 8'h08;
   localparam logic [OP_W-1:0] OP_AND = 8'h09;
   localparam logic [OP_W-1:0] OP_OR  = 8'h0A;
   localparam logic [OP_W-1:0] OP_XOR = 8'h0B;
   localparam logic [OP_W-1:0] OP_SHL = 8'h10;
   localparam logic [OP_W-1:0] OP_SHR = 8'h11;
   localparam logic [OP_W-1:0] OP_MOD = 8'h13;

   function automatic logic op_is_legal(input logic [OP_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_CMP, OP_NOT,
         OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MOD: return 1'b1;
         default:                                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_issue_wb_regfile.sv
// Architectural register file: two async read ports, one sync write port, r0 reads zero.
module alu_regfile #(
   parameter int NREGS = 8,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [2:0]    ra1,
   output logic [DW-1:0] rd1,
   input  logic [2:0]    ra2,
   output logic [DW-1:0] rd2,
   input  logic          we,
   input  logic [2:0]    wa,
   input  logic [DW-1:0] wd
);

   logic [DW-1:0] mem [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      end else if (we && wa != 3'd0) begin
         mem[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 3'd0) ? '0 : mem[ra1];
   assign rd2 = (ra2 == 3'd0) ? '0 : mem[ra2];

endmodule

// File: rtl/alu_issue_wb.sv
// Execute/writeback shell around an external combinational ALU: E stage drives
// the ALU, W stage holds the (possibly overridden) result until it retires.
module alu_issue_wb
   import alu_issue_wb_pkg::*;
#(
   parameter int NREGS = 8,
   parameter int DW    = 8,
   parameter int OPW   = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [OPW-1:0] in_op,
   input  logic [2:0]     in_rd,
   input  logic [2:0]     in_rs1,
   input  logic [2:0]     in_rs2,
   input  logic [DW-1:0]  in_imm,
   input  logic           in_use_imm,
   output logic [DW-1:0]  alu_a,
   output logic [DW-1:0]  alu_b,
   output logic [OPW-1:0] alu_op,
   input  logic [DW-1:0]  alu_result,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2:0]     out_rd,
   output logic [DW-1:0]  out_data,
   output logic           out_err
);

   logic          vld_p1, vld_p2;
   logic [2:0]    rd_p1;
   logic          w_free, accept, xfer, retire;
   logic          wb_err_p1;
   logic [DW-1:0] wb_data_p1;
   logic [DW-1:0] rf_rd1, rf_rd2;
   logic [DW-1:0] opa_p0, opb_p0, fwd2_p0;

   // Divide/modulo by zero saturates to all-ones; unknown opcodes collapse to zero.
   function automatic logic [DW:0] wb_value(input logic [OPW-1:0] op,
                                            input logic [DW-1:0]  b,
                                            input logic [DW-1:0]  res);
      if ((op == OP_DIV || op == OP_MOD) && b == '0) return {1'b1, {DW{1'b1}}};
      if (!op_is_legal(OP_W'(op)))                     return {1'b1, {DW{1'b0}}};
      return {1'b0, res};
   endfunction

   assign w_free    = !vld_p2 || out_ready;
   assign in_ready  = !vld_p1 || w_free;
   assign accept    = in_valid && in_ready;
   assign xfer      = vld_p1 && w_free;
   assign retire    = vld_p2 && out_ready;
   assign out_valid = vld_p2;

   assign {wb_err_p1, wb_data_p1} = wb_value(alu_op, alu_b, alu_result);

   alu_regfile #(.NREGS(NREGS), .DW(DW)) u_rf (
      .clk   (clk),
      .rst_n (rst_n),
      .ra1   (in_rs1),
      .rd1   (rf_rd1),
      .ra2   (in_rs2),
      .rd2   (rf_rd2),
      .we    (retire && !out_err),
      .wa    (out_rd),
      .wd    (out_data)
   );

   // ---- P0: operand read with forwarding (E result beats W result beats regfile)
   always_comb begin
      opa_p0 = rf_rd1;
      if (in_rs1 == 3'd0)                        opa_p0 = '0;
      else if (vld_p1 && rd_p1 == in_rs1)        opa_p0 = wb_data_p1;
      else if (vld_p2 && out_rd == in_rs1)       opa_p0 = out_data;
   end

   always_comb begin
      fwd2_p0 = rf_rd2;
      if (in_rs2 == 3'd0)                        fwd2_p0 = '0;
      else if (vld_p1 && rd_p1 == in_rs2)        fwd2_p0 = wb_data_p1;
      else if (vld_p2 && out_rd == in_rs2)       fwd2_p0 = out_data;
   end

   assign opb_p0 = in_use_imm ? in_imm : fwd2_p0;

   // ---- P1 (E): registered ALU inputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         rd_p1  <= '0;
         alu_a  <= '0;
         alu_b  <= '0;
         alu_op <= '0;
      end else if (accept) begin
         vld_p1 <= 1'b1;
         rd_p1  <= in_rd;
         alu_a  <= opa_p0;
         alu_b  <= opb_p0;
         alu_op <= in_op;
      end else if (xfer) begin
         vld_p1 <= 1'b0;
      end
   end

   // ---- P2 (W): retiring result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2   <= 1'b0;
         out_rd   <= '0;
         out_data <= '0;
         out_err  <= 1'b0;
      end else if (xfer) begin
         vld_p2   <= 1'b1;
         out_rd   <= rd_p1;
         out_data <= wb_data_p1;
         out_err  <= wb_err_p1;
      end else if (retire) begin
         vld_p2   <= 1'b0;
      end
   end

endmodule
